// File: rtl/hello_pkg.sv
// Shared types and constants for the HELLO scroller: FSM states,
// 3-bit character codes, active-low 7-segment patterns and the message ROM.
package hello_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCROLL = 2'd1,
        ST_HOLD   = 2'd2
    } hello_state_t;

    localparam logic [2:0] CH_H     = 3'd0;
    localparam logic [2:0] CH_E     = 3'd1;
    localparam logic [2:0] CH_L     = 3'd2;
    localparam logic [2:0] CH_O     = 3'd3;
    localparam logic [2:0] CH_BLANK = 3'd4;

    // Active-low segment patterns, bit 6..0 = g..a
    localparam logic [6:0] SEG_H     = 7'b0001001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_O     = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // msg[0..7] = H E L L O _ _ _ (element 0 is the rightmost in the concatenation)
    localparam logic [7:0][2:0] MSG_ROM = {CH_BLANK, CH_BLANK, CH_BLANK, CH_O,
                                           CH_L, CH_L, CH_E, CH_H};

    function automatic logic [2:0] msg_char(input logic [2:0] idx);
        return MSG_ROM[idx];
    endfunction

endpackage

// File: rtl/seg7_char_enc.sv
// Combinational 3-bit character code to active-low 7-segment pattern.
module seg7_char_enc
    import hello_pkg::*;
(
    input  logic [2:0] char_i,
    output logic [6:0] seg_o
);

    // Look up the segment pattern; unknown codes show blank
    always_comb begin
        seg_o = SEG_BLANK;
        case (char_i)
            CH_H:    seg_o = SEG_H;
            CH_E:    seg_o = SEG_E;
            CH_L:    seg_o = SEG_L;
            CH_O:    seg_o = SEG_O;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/hello_scroller.sv
// Six-digit "HELLO" scroller: shows msg[(win+k) mod 8] on HEX(5-k).
// IDLE blanks until Pos=0, SCROLL follows Pos, HOLD freezes the window.
// Optional macro HELLO_SCROLL_BLINK_EN blinks the frozen window in HOLD.
module hello_scroller
    import hello_pkg::*;
#(
    parameter int unsigned CHAR_CNT  = 8,
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic       Clock,
    input  logic       Clr,
    input  logic [2:0] Pos,
    input  logic       Pause,
    output logic [6:0] HEX5,
    output logic [6:0] HEX4,
    output logic [6:0] HEX3,
    output logic [6:0] HEX2,
    output logic [6:0] HEX1,
    output logic [6:0] HEX0
);

    if (BLINK_DIV < 2) begin : g_div_check
        $error("BLINK_DIV must be 2 or more");
    end

    hello_state_t      state_q, state_d;
    logic [2:0]        win_q, win_d;
    logic [5:0][6:0]   hex_q, hex_d;
    logic [2:0]        base;
    logic [5:0][2:0]   idx_w;
    logic [5:0][6:0]   seg_w;

`ifdef HELLO_SCROLL_BLINK_EN
    logic [31:0]       blink_cnt_q, blink_cnt_d;
    logic              blink_ph_q, blink_ph_d;

    // Blinking re-renders the frozen window, so HOLD reads from win
    assign base = (state_q == ST_HOLD && Pause) ? win_q : Pos;
`else
    assign base = Pos;
`endif

    // Digit d shows message character (base + 5 - d) mod CHAR_CNT
    for (genvar d = 0; d < 6; d++) begin : g_digit
        assign idx_w[d] = 3'((32'(base) + 32'(5 - d)) % CHAR_CNT);
        seg7_char_enc u_enc (
            .char_i (msg_char(idx_w[d])),
            .seg_o  (seg_w[d])
        );
    end

    // Next-state and next-display logic
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        hex_d   = hex_q;
`ifdef HELLO_SCROLL_BLINK_EN
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
`endif
        case (state_q)
            ST_IDLE: begin
                hex_d = '1;
                if (Pos == 3'd0) state_d = ST_SCROLL;
            end
            ST_SCROLL: begin
                if (Pause) begin
                    state_d = ST_HOLD;
`ifdef HELLO_SCROLL_BLINK_EN
                    blink_cnt_d = '0;
                    blink_ph_d  = 1'b0;
`endif
                end else begin
                    win_d = Pos;
                    hex_d = seg_w;
                end
            end
            ST_HOLD: begin
                if (!Pause) begin
                    state_d = ST_SCROLL;
                    win_d   = Pos;
                    hex_d   = seg_w;
`ifdef HELLO_SCROLL_BLINK_EN
                    blink_cnt_d = '0;
                    blink_ph_d  = 1'b0;
`endif
                end else begin
`ifdef HELLO_SCROLL_BLINK_EN
                    if (blink_cnt_q == 32'(BLINK_DIV - 1)) begin
                        blink_cnt_d = '0;
                        blink_ph_d  = ~blink_ph_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + 32'd1;
                    end
                    hex_d = blink_ph_d ? '1 : seg_w;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                hex_d   = '1;
            end
        endcase
    end

    // State, window and display registers with synchronous clear
    always_ff @(posedge Clock) begin
        if (Clr) begin
            state_q <= ST_IDLE;
            win_q   <= '0;
            hex_q   <= '1;
`ifdef HELLO_SCROLL_BLINK_EN
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            hex_q   <= hex_d;
`ifdef HELLO_SCROLL_BLINK_EN
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
`endif
        end
    end

    assign HEX5 = hex_q[5];
    assign HEX4 = hex_q[4];
    assign HEX3 = hex_q[3];
    assign HEX2 = hex_q[2];
    assign HEX1 = hex_q[1];
    assign HEX0 = hex_q[0];

endmodule

// File: tb/tb_hello_scroller.sv
// Self-checking bench for hello_scroller (default build, blink disabled).
module tb_hello_scroller;

    logic       Clock = 1'b0;
    logic       Clr   = 1'b1;
    logic [2:0] Pos   = 3'd0;
    logic       Pause = 1'b0;
    logic [6:0] HEX5, HEX4, HEX3, HEX2, HEX1, HEX0;

    int total = 0;
    int bad   = 0;

    hello_scroller #(.CHAR_CNT(8), .BLINK_DIV(4)) dut (
        .Clock (Clock),
        .Clr   (Clr),
        .Pos   (Pos),
        .Pause (Pause),
        .HEX5  (HEX5),
        .HEX4  (HEX4),
        .HEX3  (HEX3),
        .HEX2  (HEX2),
        .HEX1  (HEX1),
        .HEX0  (HEX0)
    );

    always #5 Clock = ~Clock;

    localparam logic [6:0] H = 7'h09;
    localparam logic [6:0] E = 7'h06;
    localparam logic [6:0] L = 7'h47;
    localparam logic [6:0] O = 7'h40;
    localparam logic [6:0] B = 7'h7F;
    localparam logic [41:0] ALLB = {B, B, B, B, B, B};

    // Reference model: mode 0 = idle, 1 = following Pos, 2 = frozen
    string       msg = "HELLO   ";
    int          m_mode = 0;
    logic [41:0] m_disp = ALLB;

    function automatic logic [6:0] seg_of(input byte c);
        case (c)
            "H":     return H;
            "E":     return E;
            "L":     return L;
            "O":     return O;
            default: return B;
        endcase
    endfunction

    function automatic logic [41:0] window(input int p);
        logic [41:0] w;
        w = '0;
        for (int k = 0; k < 6; k++)
            w[(5 - k) * 7 +: 7] = seg_of(msg[(p + k) % 8]);
        return w;
    endfunction

    function automatic logic [41:0] dut_disp();
        return {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
    endfunction

    // Apply one clock edge with the given inputs and advance the model
    task automatic step(input logic c, input logic [2:0] p, input logic pa);
        Clr = c; Pos = p; Pause = pa;
        @(posedge Clock);
        if (c) begin
            m_mode = 0;
            m_disp = ALLB;
        end else if (m_mode == 0) begin
            if (p == 3'd0) m_mode = 1;
        end else if (m_mode == 1) begin
            if (pa) m_mode = 2;
            else    m_disp = window(int'(p));
        end else begin
            if (!pa) begin
                m_mode = 1;
                m_disp = window(int'(p));
            end
        end
        #1;
    endtask

    task automatic check(input string name, input logic [41:0] exp);
        total++;
        if (dut_disp() !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, dut_disp(), exp);
        end
    endtask

    typedef struct {
        logic        clr;
        logic [2:0]  pos;
        logic        pause;
        logic [41:0] exp;
    } vec_t;

    vec_t tbl[21];

    initial begin
        tbl[0]  = '{1'b1, 3'd5, 1'b0, ALLB};
        tbl[1]  = '{1'b1, 3'd2, 1'b1, ALLB};
        tbl[2]  = '{1'b1, 3'd7, 1'b0, ALLB};
        tbl[3]  = '{1'b0, 3'd0, 1'b0, ALLB};                 // IDLE -> SCROLL
        tbl[4]  = '{1'b0, 3'd0, 1'b0, {H, E, L, L, O, B}};
        tbl[5]  = '{1'b0, 3'd3, 1'b0, {L, O, B, B, B, H}};
        tbl[6]  = '{1'b0, 3'd7, 1'b0, {B, H, E, L, L, O}};
        tbl[7]  = '{1'b0, 3'd2, 1'b0, {L, L, O, B, B, B}};
        tbl[8]  = '{1'b0, 3'd3, 1'b1, {L, L, O, B, B, B}};   // HOLD
        tbl[9]  = '{1'b0, 3'd4, 1'b1, {L, L, O, B, B, B}};
        tbl[10] = '{1'b0, 3'd5, 1'b1, {L, L, O, B, B, B}};
        tbl[11] = '{1'b0, 3'd6, 1'b1, {L, L, O, B, B, B}};
        tbl[12] = '{1'b0, 3'd6, 1'b0, {B, B, H, E, L, L}};   // jump to live Pos
        tbl[13] = '{1'b0, 3'd1, 1'b1, {B, B, H, E, L, L}};
        tbl[14] = '{1'b1, 3'd4, 1'b1, ALLB};                 // Clr mid-HOLD
        tbl[15] = '{1'b0, 3'd3, 1'b1, ALLB};
        tbl[16] = '{1'b0, 3'd5, 1'b0, ALLB};
        tbl[17] = '{1'b0, 3'd0, 1'b1, ALLB};                 // Pause ignored in IDLE
        tbl[18] = '{1'b0, 3'd4, 1'b1, ALLB};                 // frozen while still blank
        tbl[19] = '{1'b0, 3'd4, 1'b0, {O, B, B, B, H, E}};
        tbl[20] = '{1'b0, 3'd5, 1'b0, {B, B, B, H, E, L}};

        for (int i = 0; i < 21; i++) begin
            step(tbl[i].clr, tbl[i].pos, tbl[i].pause);
            check($sformatf("vec%0d", i), tbl[i].exp);
        end

        // Hand sequence: Clr held with changing Pos stays blank, then restarts
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 3'(i), 1'b0);
            check($sformatf("clr_hold%0d", i), ALLB);
        end
        step(1'b0, 3'd2, 1'b0);
        check("idle_wait_pos", ALLB);
        step(1'b0, 3'd0, 1'b0);
        check("idle_leave", ALLB);
        step(1'b0, 3'd1, 1'b0);
        check("first_window", {E, L, L, O, B, B});

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic c, pa;
            logic [2:0] p;
            c  = ($urandom_range(0, 15) == 0);
            pa = ($urandom_range(0, 3) == 0);
            p  = 3'($urandom_range(0, 7));
            step(c, p, pa);
            check($sformatf("rand%0d", i), m_disp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hello_scroller.md
HELLO_SCROLLER -- requirements
Module: hello_scroller

Interface
REQ-001 SHALL have parameter CHAR_CNT, default 8, message length in characters; fixed at 8 and matching the 3-bit Pos range.
REQ-002 SHALL have parameter BLINK_DIV, default 25000000, Clock cycles per blink half-period; legal range 2 or more.
REQ-003 SHALL have port Clock, input, 1, 50 MHz system clock; the only clock.
REQ-004 SHALL have port Clr, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port Pos, input, 3, window start index from the upstream 0..7 position counter.
REQ-006 SHALL have port Pause, input, 1, freezes the displayed window while high.
REQ-007 SHALL have ports HEX5..HEX0, output, 7 each, active-low segment patterns; bit 6..0 = g..a; HEX5 is leftmost.

Function
REQ-008 SHALL hold the fixed message ROM msg[0..7] = H, E, L, L, O, blank, blank, blank.
REQ-009 SHALL use active-low codes H=7'b0001001, E=7'b0000110, L=7'b1000111, O=7'b1000000, blank=7'b1111111.
REQ-010 SHALL implement states IDLE, SCROLL and HOLD.
REQ-011 SHALL drive all HEX outputs to blank in IDLE.
REQ-012 SHALL move from IDLE to SCROLL on the first cycle with Clr=0 and Pos=0; Pause is ignored in IDLE.
REQ-013 SHALL register the sampled Pos as win in SCROLL, and drive HEX(5-k) = msg[(win+k) mod 8] for k=0..5, with index wrap modulo 8.
REQ-014 SHALL update HEX outputs exactly one Clock after Pos is sampled, so all outputs are registered.
REQ-015 SHALL move from SCROLL to HOLD when Pause=1; win and the HEX outputs freeze from that edge on.
REQ-016 SHALL ignore Pos changes in HOLD.
REQ-017 SHALL move from HOLD to SCROLL when Pause=0; on that edge win takes the current Pos, so the display jumps to the live position with no catch-up.
REQ-018 SHALL treat undefined state encodings as IDLE on the next edge.

Reset
REQ-019 SHALL apply Clr=1 synchronously at the next Clock edge: state=IDLE, win=0, blink counter=0, blink phase=0, all HEX=7'b1111111.
REQ-020 SHALL give Clr priority over Pause and over every state transition, including mid-scroll and mid-HOLD.
REQ-021 SHALL hold IDLE while Clr=1, regardless of Pos.

Configuration
REQ-022 SHALL honour macro HELLO_SCROLL_BLINK_EN.
REQ-023 When HELLO_SCROLL_BLINK_EN is defined: in HOLD, the blink counter counts 0..BLINK_DIV-1 and toggles the phase on wrap; phase=1 forces all HEX to blank; counter and phase clear on HOLD entry and on HOLD exit.
REQ-024 When HELLO_SCROLL_BLINK_EN is undefined: no blink counter is present, and HOLD shows the frozen window steadily.

Structure
REQ-025 SHALL place the following in shared package hello_pkg: state enum hello_state_t, 3-bit character codes CH_H, CH_E, CH_L, CH_O, CH_BLANK, SEG_* pattern constants, and the message ROM constant.
REQ-026 SHALL use one sub-module, seg7_char_enc, a combinational mapping from 3-bit character code to 7-bit active-low pattern, instantiated six times.

Verification
REQ-027 Clr=1 for 3 cycles with any Pos -> all HEX=7'h7F and state=IDLE.
REQ-028 Clr=0, Pos=0 -> after 2 edges, HEX5..HEX0 = H,E,L,L,O,blank (09,06,47,47,40,7F).
REQ-029 Pos=3, then Pos=7 -> HEX5..HEX0 = 47,40,7F,7F,7F,09, then 7F,09,06,47,47,40 (wrap check).
REQ-030 SCROLL at Pos=2, Pause=1, Pos stepping 3..6 -> display stays 47,47,40,7F,7F,7F; Pause=0 at Pos=6 -> next edge shows 7F,7F,09,06,47,47.
REQ-031 Clr=1 asserted during HOLD with Pause still 1 -> next edge: all 7F, IDLE; after Clr=0, IDLE is left only when Pos=0.
REQ-032 With HELLO_SCROLL_BLINK_EN defined and BLINK_DIV=4, HOLD entered -> display alternates window for 4 cycles / blank for 4 cycles; with the macro undefined -> window held steadily.
